reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Shares the single write port of the CPU register file between NREQ producers (ALU, load unit, move/immediate path). Each cycle it picks one valid requester by round-robin priority, completes a valid/ready handshake with it, and drives the register-file write port one cycle later from registered outputs. It sits between the execute-stage producers and the 16-bit register bank.

## Interface

**Parameters**
- `WIDTH`, 16: data width of the register file.
- `ADDR_W`, 3: register address width (8 registers).
- `NREQ`, 3: number of requesters, range 2..8.

**Ports**
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, NREQ: per-requester write request.
- `req_ready`, output, NREQ: per-requester accept; one-hot or zero.
- `req_addr`, input, NREQ*ADDR_W: flattened destination addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `req_data`, input, NREQ*WIDTH: flattened write data; requester i uses bits [i*WIDTH +: WIDTH].
- `stall`, input, 1: write port unavailable; blocks all grants.
- `wr_en`, output, 1: register-file write enable.
- `wr_addr`, output, ADDR_W: register-file write address.
- `wr_data`, output, WIDTH: register-file write data.
- `grant_id`, output, $clog2(NREQ): index of the requester whose write is on `wr_*`.

## Operation

- **State:** round-robin pointer `ptr` (0..NREQ-1), plus output registers `wr_en`, `wr_addr`, `wr_data`, `grant_id`.
- **Arbitration (combinational):**
  - Search order is ptr, ptr+1, …, wrapping modulo NREQ.
  - The first i with `req_valid[i]=1` wins.
  - `req_ready[i]=1` only for the winner, and only when `stall=0`.
- **Transfer:** occurs when `req_valid[i] & req_ready[i]`. At most one transfer per cycle.
- **Requester obligations:** hold `req_valid`, `req_addr` and `req_data` stable until accepted. Deasserting before acceptance is allowed; the request is then dropped with no side effect.
- **Pointer update:**
  - On a transfer from i, `ptr <= (i+1) mod NREQ`.
  - With no transfer (no valid request or `stall=1`), `ptr` holds.
- **Output update:**
  - On a transfer: `wr_en<=1`, and `wr_addr`, `wr_data`, `grant_id` load the winner's values.
  - Otherwise `wr_en<=0`, and the other outputs hold their last value.
- **Same-address requests** from different requesters are not merged. They are written in grant order, so the later grant wins in the register file.
- **NREQ wrap:** ptr = NREQ-1 followed by a grant to NREQ-1 sets ptr to 0.

## Timing

- **Reset values:** `wr_en=0`, `wr_addr=0`, `wr_data=0`, `grant_id=0`, `ptr=0`. `req_ready` is 0 while `reset=1`.
- **Latency:** a transfer in cycle N gives `wr_en=1` with that request's addr/data in cycle N+1, for exactly one cycle per transfer.
- **Throughput:** one write per cycle. Back-to-back transfers give continuous `wr_en=1`.
- **`stall`** is sampled combinationally in the same cycle. Stall asserted in cycle N means no transfer in N, and `wr_en=0` in N+1.
- **Reset mid-operation:** asynchronous clear of all state. A transfer accepted in the cycle before reset assertion is lost if reset arrives before the N+1 edge. After reset release, arbitration restarts from requester 0.
- **Simultaneous reset and valid:** no `req_ready` and no transfer.

## Configuration

- **Macro:** `REG_WR_ARB_FIXED_PRIO_EN`.
- **Defined:** fixed priority, where the lowest valid index always wins. `ptr` is not implemented and is treated as constant 0. All other behaviour (handshake, stall, latency) is unchanged.
- **Undefined (default):** round-robin as described above.

## Test plan

Directed scenarios, each with NREQ=3 and WIDTH=16:

- **Reset:** assert `reset` with all `req_valid=3'b111`. Required: `req_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`. After release, the first grant goes to requester 0.
- **Single request:** requester 1 writes addr 5, data 16'hAAAA. Required: `req_ready=3'b010` in the same cycle; next cycle `wr_en=1`, `wr_addr=5`, `wr_data=16'hAAAA`, `grant_id=1`; the following cycle `wr_en=0`.
- **Round-robin fairness:** all three requesters valid continuously, with data 16'hF0F0, 16'h5555, 16'h0F0F. Required grant order 0,1,2,0,1,2 with `wr_en` high every cycle. Under `REG_WR_ARB_FIXED_PRIO_EN`, the order is 0,0,0,… until requester 0 drops.
- **Stall:** requester 2 is valid and `stall=1` for 3 cycles. Required: `req_ready=0` and `wr_en=0` throughout, `ptr` unchanged. On the cycle stall drops, requester 2 is accepted and written the following cycle.
- **Wrap and same address:** requesters 2 and 0 both target addr 3, with `ptr=2`. Required: requester 2 is written first, then requester 0, so the final register value is requester 0's data. `ptr` ends at 1.
- **Reset mid-transfer:** accept requester 0 (data 16'h1234), then assert `reset` before the next edge. Required: `wr_en` stays 0 and `wr_data=0`; no write occurs.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester valid/ready handshake plus register-file write port.
// master = producers/register-file side, slave = arbiter side.
interface reg_write_arbiter_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3,
   parameter int NREQ   = 3
);
   localparam int IW = $clog2(NREQ);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*WIDTH-1:0]  req_data;
   logic                   stall;
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [WIDTH-1:0]       wr_data;
   logic [IW-1:0]          grant_id;
   modport master (
      output req_valid, req_addr, req_data, stall,
      input  req_ready, wr_en, wr_addr, wr_data, grant_id
   );
   modport slave (
      input  req_valid, req_addr, req_data, stall,
      output req_ready, wr_en, wr_addr, wr_data, grant_id
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sharing one register-file write port among NREQ producers.
// Define REG_WR_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins, no pointer).
module reg_write_arbiter #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3,
   parameter int NREQ   = 3
) (
   input logic               clk,
   input logic               reset,
   reg_write_arbiter_if.slave bus
);
   localparam int IW = $clog2(NREQ);
   logic [IW-1:0]     ptr, win;
   logic              found, xfer;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0]  wr_data_q, wr_data_d;
   logic [IW-1:0]     grant_id_q, grant_id_d;

`ifdef REG_WR_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   logic [IW-1:0] ptr_q, ptr_d;
   assign ptr = ptr_q;
   always_comb ptr_d = xfer ? ((win == IW'(NREQ-1)) ? '0 : win + 1'b1) : ptr_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) ptr_q <= '0;
      else ptr_q <= ptr_d;
`endif

   // first valid requester at or after ptr, wrapping modulo NREQ
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++)
         if (!found && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
            found = 1'b1;
            win   = IW'((int'(ptr) + k) % NREQ);
         end
   end

   assign xfer          = found & ~bus.stall & ~reset;
   assign bus.req_ready = xfer ? (NREQ'(1'b1) << win) : '0;

   always_comb begin
      wr_en_d    = xfer;
      wr_addr_d  = xfer ? bus.req_addr[win*ADDR_W +: ADDR_W] : wr_addr_q;
      wr_data_d  = xfer ? bus.req_data[win*WIDTH +: WIDTH] : wr_data_q;
      grant_id_d = xfer ? win : grant_id_q;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         grant_id_q <= '0;
      end else begin
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         grant_id_q <= grant_id_d;
      end

   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.grant_id = grant_id_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed scenarios checked every cycle against a behavioural arbiter model.
// Honours REG_WR_ARB_FIXED_PRIO_EN for the priority-dependent expectations.
module tb_reg_write_arbiter;
   localparam int W = 16, A = 3, N = 3;
   logic clk = 1'b0, reset = 1'b0;
   always #5 clk = ~clk;

   reg_write_arbiter_if #(.WIDTH(W), .ADDR_W(A), .NREQ(N)) bus();
   reg_write_arbiter #(.WIDTH(W), .ADDR_W(A), .NREQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0, errors = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // model: pointer as an integer, outputs as last accepted request
   int m_ptr, m_gid, m_w, c_w;
   logic m_en;
   logic [A-1:0] m_addr;
   logic [W-1:0] m_data;
   logic [N-1:0] c_ready, acc;
   logic [W-1:0] rf [8];

   function automatic int pick();
      int b;
`ifdef REG_WR_ARB_FIXED_PRIO_EN
      b = 0;
`else
      b = m_ptr;
`endif
      for (int k = 0; k < N; k++) if (bus.req_valid[(b + k) % N]) return (b + k) % N;
      return -1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_ptr <= 0; m_en <= 1'b0; m_addr <= '0; m_data <= '0; m_gid <= 0;
      end else begin
         m_w = pick();
         if (!bus.stall && m_w >= 0) begin
            m_en   <= 1'b1;
            m_addr <= bus.req_addr[m_w*A +: A];
            m_data <= bus.req_data[m_w*W +: W];
            m_gid  <= m_w;
            m_ptr  <= (m_w + 1) % N;
         end else m_en <= 1'b0;
      end
   end

   always @(posedge clk) begin
      acc <= bus.req_valid & bus.req_ready;
      if (bus.wr_en) rf[bus.wr_addr] <= bus.wr_data;
   end

   always @(negedge clk) begin
      c_w = pick();
      c_ready = (reset || bus.stall || c_w < 0) ? '0 : N'(1 << c_w);
      chk("ready", 32'(bus.req_ready), 32'(c_ready));
      chk("wr_en", 32'(bus.wr_en), 32'(m_en));
      chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
      chk("wr_data", 32'(bus.wr_data), 32'(m_data));
      chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0; bus.stall = 1'b0;
      #1 reset = 1'b1;
      bus.req_valid = 3'b111;
      bus.req_addr  = {3'd2, 3'd1, 3'd0};
      bus.req_data  = {16'h0F0F, 16'h5555, 16'hF0F0};
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_wr_en", 32'(bus.wr_en), 0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 0);
      chk("rst_wr_data", 32'(bus.wr_data), 0);
      cyc(); reset = 1'b0;
      @(negedge clk); chk("first_ready", 32'(bus.req_ready), 32'h1);
      cyc(); bus.req_valid = '0;
      @(negedge clk);
      chk("first_gid", 32'(bus.grant_id), 0);
      chk("first_wr_en", 32'(bus.wr_en), 1);
      cyc();
      // single request from requester 1
      bus.req_valid = 3'b010; bus.req_addr[3 +: 3] = 3'd5; bus.req_data[16 +: 16] = 16'hAAAA;
      @(negedge clk); chk("single_ready", 32'(bus.req_ready), 32'h2);
      cyc(); bus.req_valid = '0;
      @(negedge clk);
      chk("single_wr_en", 32'(bus.wr_en), 1);
      chk("single_addr", 32'(bus.wr_addr), 5);
      chk("single_data", 32'(bus.wr_data), 32'hAAAA);
      chk("single_gid", 32'(bus.grant_id), 1);
      cyc();
      @(negedge clk); chk("single_after", 32'(bus.wr_en), 0);
      // fairness from a fresh pointer
      #1 reset = 1'b1;
      cyc(); reset = 1'b0;
      bus.req_addr = {3'd2, 3'd1, 3'd0};
      bus.req_data = {16'h0F0F, 16'h5555, 16'hF0F0};
      bus.req_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (i == 5) bus.req_valid = '0;
         @(negedge clk);
`ifdef REG_WR_ARB_FIXED_PRIO_EN
         chk("rr_gid", 32'(bus.grant_id), 0);
`else
         chk("rr_gid", 32'(bus.grant_id), 32'(i % 3));
`endif
         chk("rr_wr_en", 32'(bus.wr_en), 1);
      end
      cyc();
      // stall with requester 2 waiting
      bus.stall = 1'b1; bus.req_valid = 3'b100; bus.req_addr[6 +: 3] = 3'd6;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_ready", 32'(bus.req_ready), 0);
         chk("stall_wr_en", 32'(bus.wr_en), 0);
         cyc();
      end
      bus.stall = 1'b0;
      @(negedge clk); chk("unstall_ready", 32'(bus.req_ready), 32'h4);
      cyc(); bus.req_valid = '0;
      @(negedge clk);
      chk("unstall_gid", 32'(bus.grant_id), 2);
      chk("unstall_data", 32'(bus.wr_data), 32'h0F0F);
      // requester 1 once so the pointer sits at 2
      cyc(); bus.req_valid = 3'b010;
      cyc(); bus.req_valid = '0;
      bus.req_addr = {3'd3, 3'd1, 3'd3};
      bus.req_data = {16'hCAFE, 16'h5555, 16'hBEEF};
      cyc(); bus.req_valid = 3'b101;
      @(negedge clk);
`ifndef REG_WR_ARB_FIXED_PRIO_EN
      chk("wrap_ready", 32'(bus.req_ready), 32'h4);
`endif
      repeat (4) begin
         cyc();
         bus.req_valid = bus.req_valid & ~acc;
      end
      @(negedge clk);
`ifdef REG_WR_ARB_FIXED_PRIO_EN
      chk("same_addr_rf", 32'(rf[3]), 32'hCAFE);
`else
      chk("same_addr_rf", 32'(rf[3]), 32'hBEEF);
`endif
      cyc(); bus.req_valid = 3'b111;
      @(negedge clk);
`ifdef REG_WR_ARB_FIXED_PRIO_EN
      chk("ptr_after_wrap", 32'(bus.req_ready), 32'h1);
`else
      chk("ptr_after_wrap", 32'(bus.req_ready), 32'h2);
`endif
      // accept requester 0, then reset before the write lands
      cyc(); bus.req_valid = 3'b001; bus.req_data[0 +: 16] = 16'h1234;
      @(negedge clk); chk("mid_ready", 32'(bus.req_ready), 32'h1);
      #2 reset = 1'b1; bus.req_valid = '0;
      cyc();
      chk("mid_wr_en", 32'(bus.wr_en), 0);
      chk("mid_wr_data", 32'(bus.wr_data), 0);
      cyc(); reset = 1'b0;
      @(negedge clk); chk("post_rst_wr_en", 32'(bus.wr_en), 0);
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
